pll_lock_sequencer: RTL
=======================

Name: pll_lock_sequencer

Overview:
- Controls the reset of the CPU clock PLL: the altera_pll wrapper with a 50 MHz refclk, a 200 MHz outclk_0, and rst/locked pins.
- Runs entirely on the 50 MHz reference clock, which is alive before the PLL locks.
- Sequences each power-up: asserts PLL reset, waits for lock with a timeout, debounces lock, retries on timeout, then releases the downstream system reset.
- Monitors lock during run and re-sequences if lock is lost.

Parameters:
- RST_CYCLES, 16: refclk cycles pll_rst is held high on each entry to RESET_PLL (>=1).
- LOCK_TIMEOUT, 1000: refclk cycles allowed in WAIT_LOCK before a timeout (>=2).
- STABLE_CYCLES, 64: consecutive synchronized-lock cycles required before RUN (>=1).
- MAX_RETRIES, 3: timeouts re-sequenced before entering FAIL.
- SYNC_STAGES, 2: flip-flop stages synchronizing pll_locked (>=2).

Ports:
- refclk  in  1  reference clock; only clock of the block.
- rst  in  1  synchronous active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- restart  in  1  single-cycle pulse requesting full re-sequence.
- pll_rst  out  1  drives the PLL rst pin.
- sys_rst  out  1  active-high reset to logic clocked by outclk_0.
- ready  out  1  PLL locked and stable; system running.
- fail  out  1  retry budget exhausted.
- lost_lock  out  1  one-cycle pulse when lock drops in RUN.
- retry_cnt  out  clog2(MAX_RETRIES+1)  timeouts in the current attempt.

Behaviour:
- Interface: one clock, refclk; reset rst is synchronous and active-high. All flops, including the sync chain, update only on the refclk rising edge.
- Reset values: state=RESET_PLL, cycle counter=0, pll_rst=1, sys_rst=1, ready=0, fail=0, lost_lock=0, retry_cnt=0, sync chain all 0.
- rst asserted in any state returns to these values on the next edge.
- pll_locked passes through SYNC_STAGES flops to give lock_s. Latency from pll_locked to lock_s is SYNC_STAGES cycles.
- Outputs are Moore, decoded from the registered state:
  - pll_rst=1 in RESET_PLL and FAIL.
  - sys_rst=1 in every state except RUN.
  - ready=1 only in RUN.
  - fail=1 only in FAIL.
- One cycle counter, cleared on every state change.
- RESET_PLL: lasts exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Otherwise, after LOCK_TIMEOUT cycles in the state:
    - if retry_cnt==MAX_RETRIES -> FAIL;
    - else retry_cnt+1 and go to RESET_PLL.
- STABLE:
  - lock_s=0 -> WAIT_LOCK. The timeout restarts from 0 and retry_cnt is unchanged.
  - lock_s=1 for STABLE_CYCLES consecutive cycles (including the entry cycle) -> RUN.
- RUN:
  - retry_cnt clears to 0 on entry.
  - lock_s=0 -> lost_lock pulses high for exactly one cycle, concurrent with the transition to RESET_PLL.
- FAIL: terminal. Exits only on restart or rst.
- restart:
  - From any state, goes to RESET_PLL with counter=0 and retry_cnt=0.
  - A restart during RESET_PLL restarts the full RST_CYCLES hold.
  - Priority: rst > restart > lock-loss/timeout/advance.
- Simultaneous restart and lock loss in RUN: lost_lock still pulses and the state goes to RESET_PLL.
- Counter width is clog2 of max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1. It saturates and never wraps.
- pll_locked glitches shorter than a cycle may be missed. A single low cycle of lock_s in STABLE or RUN is always acted on; there is no filtering beyond the sync chain.

Test Plan:
- Nominal lock (defaults):
  - Stimulus: release rst; pll_locked held 0, then tied high after pll_rst falls.
  - Response: pll_rst high exactly 16 cycles.
  - Response: ready and sys_rst=0 exactly 2+64 cycles after pll_locked rises (sync latency plus STABLE), retry_cnt=0.
- Never locks:
  - Stimulus: pll_locked held 0.
  - Response: 3 RESET_PLL re-entries, each after 1000 WAIT_LOCK cycles, with retry_cnt stepping 1, 2, 3.
  - Response: fail=1 and pll_rst=1 after the 4th timeout, and the state holds there.
  - Stimulus: then a restart pulse. Response: fail=0, retry_cnt=0, pll_rst high 16 cycles.
- Bouncing lock:
  - Stimulus: pll_locked high 40 cycles, low 1 cycle, then high.
  - Response: STABLE aborts to WAIT_LOCK; ready only after 64 further consecutive lock_s cycles; no retry consumed.
- Lock loss in RUN:
  - Stimulus: drop pll_locked.
  - Response: exactly 2 cycles later lost_lock pulses for 1 cycle, ready falls, sys_rst rises, pll_rst rises.
  - Response: full re-sequence to ready.
- Late lock within the timeout:
  - Stimulus: lock arrives at WAIT_LOCK cycle 998.
  - Response: no timeout; enters STABLE.
- Mid-sequence reset:
  - Stimulus: rst asserted for 1 cycle during STABLE, and separately during FAIL.
  - Response: all outputs at reset values on the next edge; sequence restarts from RESET_PLL.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the CPU clock PLL, clocked by the 50 MHz refclk.
// Holds the PLL in reset, waits for a debounced lock with timeout and retry, then releases sys_rst.
module pll_lock_sequencer #(
  parameter  int RST_CYCLES    = 16,
  parameter  int LOCK_TIMEOUT  = 1000,
  parameter  int STABLE_CYCLES = 64,
  parameter  int MAX_RETRIES   = 3,
  parameter  int SYNC_STAGES   = 2,
  localparam int RW            = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          restart,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fail,
  output logic          lost_lock,
  output logic [RW-1:0] retry_cnt
);
  localparam int M01     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_TOP = (M01 > STABLE_CYCLES) ? M01 : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_TOP + 1);
  // The WAIT_LOCK cycle that sees lock_s counts as the first stable cycle.
  localparam int STB_END = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [RW-1:0] rc_t;

  localparam cnt_t RST_LAST = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t TO_LAST  = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t STB_LAST = cnt_t'(STB_END);
  localparam rc_t  RC_MAX   = rc_t'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state_q, state_n;
  cnt_t                   cnt_q;
  rc_t                    retry_n;
  logic                   lost_n;
  logic                   cnt_clr;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_n = state_q;
    retry_n = retry_cnt;
    lost_n  = 1'b0;
    case (state_q)
      S_RESET_PLL: if (cnt_q == RST_LAST) state_n = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_n = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_cnt == RC_MAX) begin
            state_n = S_FAIL;
          end else begin
            state_n = S_RESET_PLL;
            retry_n = retry_cnt + rc_t'(1);
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_n = S_WAIT_LOCK;
        end else if (cnt_q >= STB_LAST) begin
          state_n = S_RUN;
          retry_n = '0;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_n = S_RESET_PLL;
          lost_n  = 1'b1;
        end
      end
      S_FAIL:  state_n = S_FAIL;
      default: state_n = S_RESET_PLL;
    endcase
    // restart overrides everything but still lets a concurrent lock loss be reported
    if (restart) begin
      state_n = S_RESET_PLL;
      retry_n = '0;
    end
    cnt_clr = restart || (state_n != state_q);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      retry_cnt <= '0;
      lost_lock <= 1'b0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_n;
      retry_cnt <= retry_n;
      lost_lock <= lost_n;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      if (cnt_clr)          cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  assign pll_rst = (state_q == S_RESET_PLL) || (state_q == S_FAIL);
  assign sys_rst = (state_q != S_RUN);
  assign ready   = (state_q == S_RUN);
  assign fail    = (state_q == S_FAIL);

endmodule
